lcd_pixel_unpacker: RTL and testbench

Consumes the 64-bit words that the frame buffer streaming stage writes into the pixel FIFO and delivers one 24-bit RGB pixel per LCD pixel tick to the LCD timing/output logic. Each FIFO word carries two 32-bit pixels. A two-word prefetch queue hides FIFO read latency. Underflow is handled deterministically: a fixed colour is output and the event is counted.

---
 rtl/lcd_pixel_unpacker.sv | 128 ++++++++++++
 tb/tb_lcd_pixel_unpacker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_unpacker.sv
// lcd_pixel_unpacker
// Unpacks 64-bit pixel FIFO words (two 32-bit pixels each) into one 24-bit
// RGB pixel per enabled LCD tick. A two-word prefetch queue (head/tail)
// hides FIFO latency; an empty queue on an enabled tick outputs
// UNDERFLOW_COLOR.
// Optional feature macro: LCD_PIXEL_UNPACKER_UNDERFLOW_COUNT_EN
//   defined   -> 16-bit saturating underflow counter on underflow_count
//   undefined -> underflow_count tied to zero
module lcd_pixel_unpacker #(
  parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000,
  parameter bit          LOW_PIXEL_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] fifo_read_data,
  output logic        fifo_read,
  input  logic        fifo_read_wait,
  input  logic        lcd_tick,
  input  logic        lcd_data_enable,
  output logic [7:0]  lcd_red,
  output logic [7:0]  lcd_green,
  output logic [7:0]  lcd_blue,
  output logic [15:0] underflow_count
);

  // Slots keep only the 24 colour bits of each pixel: {high pixel, low pixel}.
  logic [47:0] head_q, head_d;
  logic [47:0] tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic        half_q, half_d;
  logic [23:0] pix_q, pix_d;

  logic        accept;
  logic        consume;
  logic        underflow;
  logic        pop;
  logic [1:0]  eff_count;
  logic        sel_hi;
  logic [47:0] word_in;
  logic        unused_bits;

  assign word_in     = {fifo_read_data[55:32], fifo_read_data[23:0]};
  assign unused_bits = ^{fifo_read_data[63:56], fifo_read_data[31:24]};

  // Read request depends only on registered queue occupancy (and reset).
  assign fifo_read = !reset && (count_q < 2'd2);
  assign accept    = fifo_read && !fifo_read_wait;
  assign consume   = lcd_tick && lcd_data_enable;
  assign underflow = consume && (count_q == 2'd0);
  assign pop       = consume && (count_q != 2'd0) && half_q;
  assign eff_count = count_q - {1'b0, pop};
  assign sel_hi    = LOW_PIXEL_FIRST ? half_q : !half_q;

  // Next-state for the queue, half selector and output pixel.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    half_d  = half_q;
    pix_d   = pix_q;
    if (consume) begin
      if (count_q != 2'd0) begin
        pix_d  = sel_hi ? head_q[47:24] : head_q[23:0];
        half_d = !half_q;
        if (half_q) begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
          half_d  = 1'b0;
        end
      end else begin
        pix_d = UNDERFLOW_COLOR;
      end
    end
    // A word accepted during an underflow tick only fills the queue; the
    // tick itself already took the underflow colour above.
    if (accept) begin
      if (eff_count == 2'd0) begin
        head_d = word_in;
      end else begin
        tail_d = word_in;
      end
      count_d = eff_count + 2'd1;
    end
  end

  // Queue and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      half_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      half_q  <= half_d;
      pix_q   <= pix_d;
    end
  end

  assign lcd_red   = pix_q[7:0];
  assign lcd_green = pix_q[15:8];
  assign lcd_blue  = pix_q[23:16];

`ifdef LCD_PIXEL_UNPACKER_UNDERFLOW_COUNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  assign uf_cnt_d = (underflow && (uf_cnt_q != 16'hFFFF)) ? uf_cnt_q + 16'd1 : uf_cnt_q;

  // Saturating underflow tick counter, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      uf_cnt_q <= '0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign underflow_count = uf_cnt_q;
`else
  logic unused_underflow;
  assign unused_underflow = underflow;
  assign underflow_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_pixel_unpacker.sv
// Directed bench for lcd_pixel_unpacker: two instances (low-first with a
// non-zero underflow colour, high-first with the default colour) share one
// behavioural FIFO.
module tb_lcd_pixel_unpacker;

  localparam logic [23:0] UC = 24'hA5B6C7;
  localparam logic [63:0] W0 = 64'h00332211_00665544;
  localparam logic [63:0] W1 = 64'hFF998877_00CCBBAA;
  localparam logic [63:0] W2 = 64'h00F0E0D0_00C0B0A0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] fifo_read_data = '0;
  logic        fifo_read_wait = 1'b1;
  logic        fifo_read, fifo_read_r;
  logic        lcd_tick = 1'b0;
  logic        lcd_data_enable = 1'b0;
  logic [7:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic [15:0] ufc_a, ufc_b;

  logic [63:0] fifo_q[$];
  logic        stall = 1'b0;
  int          accepts = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_ufc3, exp_ufc_sat;

  always #5 clock = ~clock;

  lcd_pixel_unpacker #(.UNDERFLOW_COLOR(UC), .LOW_PIXEL_FIRST(1'b1)) u_dut (
    .clock(clock), .reset(reset), .fifo_read_data(fifo_read_data),
    .fifo_read(fifo_read), .fifo_read_wait(fifo_read_wait),
    .lcd_tick(lcd_tick), .lcd_data_enable(lcd_data_enable),
    .lcd_red(red_a), .lcd_green(green_a), .lcd_blue(blue_a),
    .underflow_count(ufc_a));

  lcd_pixel_unpacker #(.LOW_PIXEL_FIRST(1'b0)) u_rev (
    .clock(clock), .reset(reset), .fifo_read_data(fifo_read_data),
    .fifo_read(fifo_read_r), .fifo_read_wait(fifo_read_wait),
    .lcd_tick(lcd_tick), .lcd_data_enable(lcd_data_enable),
    .lcd_red(red_b), .lcd_green(green_b), .lcd_blue(blue_b),
    .underflow_count(ufc_b));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FIFO model: accept decided mid-cycle, word popped at the edge, then
  // waitrequest/data refreshed shortly after the edge.
  initial begin
    logic take;
    forever begin
      @(negedge clock);
      #1;
      take = fifo_read && !fifo_read_wait;
      @(posedge clock);
      if (take) begin
        void'(fifo_q.pop_front());
        accepts++;
      end
      #2;
      fifo_read_wait = stall || (fifo_q.size() == 0);
      fifo_read_data = (fifo_q.size() == 0) ? 64'h0 : fifo_q[0];
    end
  end

  task automatic do_tick(input logic en);
    @(negedge clock);
    lcd_tick = 1'b1;
    lcd_data_enable = en;
    @(negedge clock);
    lcd_tick = 1'b0;
    lcd_data_enable = 1'b0;
  endtask

  function automatic logic [31:0] rgb_a();
    return {8'h0, blue_a, green_a, red_a};
  endfunction

  function automatic logic [31:0] rgb_b();
    return {8'h0, blue_b, green_b, red_b};
  endfunction

  initial begin
`ifdef LCD_PIXEL_UNPACKER_UNDERFLOW_COUNT_EN
    exp_ufc3    = 16'd3;
    exp_ufc_sat = 16'hFFFF;
`else
    exp_ufc3    = 16'd0;
    exp_ufc_sat = 16'd0;
`endif
    // Reset with words already waiting: no reads may be issued.
    fifo_q.push_back(W0);
    fifo_q.push_back(W1);
    repeat (4) @(negedge clock);
    check_val("rst_fifo_read", {31'b0, fifo_read}, 32'd0);
    check_val("rst_rgb", rgb_a(), 32'h0);
    check_val("rst_ufc", {16'h0, ufc_a}, 32'h0);
    check_val("rst_accepts", accepts, 0);
    reset = 1'b0;

    // Prefetch: exactly two words taken, then the request drops.
    repeat (6) @(negedge clock);
    check_val("pf_accepts", accepts, 2);
    check_val("pf_fifo_read", {31'b0, fifo_read}, 32'd0);
    check_val("pf_rgb_idle", rgb_a(), 32'h0);

    // Ordering with blanking ticks interleaved.
    do_tick(1'b1);
    check_val("ord0_lo", rgb_a(), 32'h665544);
    check_val("ord0_hi", rgb_b(), 32'h332211);
    do_tick(1'b1);
    check_val("ord1_lo", rgb_a(), 32'h332211);
    check_val("ord1_hi", rgb_b(), 32'h665544);
    do_tick(1'b0);
    do_tick(1'b0);
    check_val("blank_hold", rgb_a(), 32'h332211);
    check_val("blank_accepts", accepts, 2);
    do_tick(1'b1);
    check_val("ord2_lo", rgb_a(), 32'hCCBBAA);
    check_val("ord2_hi", rgb_b(), 32'h998877);
    do_tick(1'b0);
    check_val("blank_half_hold", rgb_a(), 32'hCCBBAA);
    do_tick(1'b1);
    check_val("ord3_lo", rgb_a(), 32'h998877);
    check_val("ord3_hi", rgb_b(), 32'hCCBBAA);

    // Underflow: queue empty, FIFO stalled.
    stall = 1'b1;
    repeat (3) do_tick(1'b1);
    check_val("uf_color_a", rgb_a(), {8'h0, UC});
    check_val("uf_color_b", rgb_b(), 32'h0);
    check_val("uf_count", {16'h0, ufc_a}, {16'h0, exp_ufc3});

    // Release with W2: first pixel of W2 next, nothing skipped.
    fifo_q.push_back(W2);
    stall = 1'b0;
    repeat (4) @(negedge clock);
    do_tick(1'b1);
    check_val("rel0_lo", rgb_a(), 32'hC0B0A0);
    check_val("rel0_hi", rgb_b(), 32'hF0E0D0);
    do_tick(1'b1);
    check_val("rel1_lo", rgb_a(), 32'hF0E0D0);
    check_val("uf_count_hold", {16'h0, ufc_a}, {16'h0, exp_ufc3});

    // Mid-stream reset after three pixels.
    fifo_q.push_back(W0);
    fifo_q.push_back(W1);
    fifo_q.push_back(W2);
    repeat (6) @(negedge clock);
    do_tick(1'b1);
    do_tick(1'b1);
    do_tick(1'b1);
    check_val("mid_px3", rgb_a(), 32'hCCBBAA);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_val("mid_rst_rgb", rgb_a(), 32'h0);
    check_val("mid_rst_ufc", {16'h0, ufc_a}, 32'h0);
    check_val("mid_rst_fifo_read", {31'b0, fifo_read}, 32'd0);
    fifo_q.delete();
    fifo_q.push_back(W1);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    do_tick(1'b1);
    check_val("mid_refill_lo", rgb_a(), 32'hCCBBAA);
    check_val("mid_refill_hi", rgb_b(), 32'h998877);

    // Saturation: 70000 consecutive enabled ticks with the FIFO stalled.
    stall = 1'b1;
    @(negedge clock);
    lcd_tick = 1'b1;
    lcd_data_enable = 1'b1;
    repeat (70000) @(negedge clock);
    lcd_tick = 1'b0;
    lcd_data_enable = 1'b0;
    @(negedge clock);
    check_val("sat_count", {16'h0, ufc_a}, {16'h0, exp_ufc_sat});
    check_val("sat_color", rgb_a(), {8'h0, UC});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
